mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Consumer side of the execute/memory pipeline register: reads the registered mem_* stage signals and executes loads and stores against data memory over a valid/ready request and response-valid interface. Produces the registered memory/writeback payload and a stall that freezes the upstream pipeline while an access is outstanding. Performs byte-lane steering, load sign/zero extension, misalignment detection and bus-timeout recovery.

Parameters:
TIMEOUT_CYC, 64, cycles in REQ+WAIT before abandoning an access (0 disables)
XLEN, 32, data/address width

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
mem_alu_out_in  in  XLEN  effective address / ALU result
mem_rv1_in  in  XLEN  store data (rs2 value)
mem_pc_imm_in  in  XLEN  PC+imm (AUIPC)
mem_imm_in  in  XLEN  immediate (LUI)
mem_rd_in  in  5  destination register
mem_reg_in_sel_in  in  2  wb source: 00 ALU, 01 load, 10 imm, 11 pc_imm
mem_dwe_in  in  4  store byte enables, lane-0 pattern (0001/0011/1111); 0000 = not a store
mem_func3_in  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
mem_mem_reg_in  in  1  instruction is a load
mem_reg_wr_in  in  1  register write enable
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_we  out  4  byte write strobes (0000 = read)
dmem_wdata  out  XLEN  lane-steered store data
dmem_rsp_valid  in  1  read data valid
dmem_rdata  in  XLEN  read data
stall  out  1  hold upstream pipeline registers
wb_rd  out  5  registered destination
wb_reg_wr  out  1  registered write enable
wb_data  out  XLEN  registered writeback value
misalign_err  out  1  one-cycle pulse, misaligned access dropped
bus_err  out  1  one-cycle pulse, access timed out

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, timeout counter 0, all wb_*/err outputs 0; dmem_req_valid and stall 0 while reset_n=0. A reset mid-access abandons it; a later dmem_rsp_valid is ignored.
- mem op = mem_mem_reg_in | (mem_dwe_in != 0). a = mem_alu_out_in[1:0].
- Misaligned: H/HU with a[0]=1, or W with a!=0 (stores: dwe 0011 with a[0]=1, 1111 with a!=0). No request, stall=0; next edge: misalign_err=1, wb_reg_wr=0.
- Store steering: dmem_we = mem_dwe_in << a; dmem_wdata = mem_rv1_in << 8*a. Loads: dmem_we=0000.
- FSM IDLE / REQ / WAIT:
  IDLE, aligned mem op: dmem_req_valid=1 combinationally. Store accepted -> complete, stay IDLE. Load accepted -> WAIT. Not accepted -> REQ.
  REQ: dmem_req_valid=1, address/strobes held (inputs stable under stall). Accept -> store completes, IDLE; load -> WAIT.
  WAIT: dmem_req_valid=0; dmem_rsp_valid -> load completes, IDLE.
- stall = mem op & ~complete_this_cycle & ~misaligned. Completion cycle has stall=0 so upstream advances on the same edge; completed op is never reissued.
- wb_* load every edge from the completing/non-mem instruction; when stall=1, wb_reg_wr=0 (bubble). Non-mem latency 1 cycle; load minimum 2 (accept, response); store 1.
- Load data: byte at rdata[8a+7:8a], half at rdata[16a[1]+15:16a[1]]; sign-extend B/H, zero-extend BU/HU.
- wb_data mux per mem_reg_in_sel_in; wb_reg_wr = mem_reg_wr_in except misalign/timeout/stall.
- Timeout: counter clears on entering REQ/WAIT, increments each cycle there; reaching TIMEOUT_CYC -> IDLE, bus_err pulse, wb_reg_wr=0, stall drops that cycle.
- dmem_rsp_valid outside WAIT ignored.

Decomposition:
- Package lsu_pkg: wb-select encodings, func3 width codes, state enum {IDLE,REQ,WAIT}, store-enable patterns.
- Sub-module load_align (combinational: rdata, a, func3 -> extended data).

Test Plan:
- ALU op, sel=00, alu_out=0x1234, rd=5, reg_wr=1 -> next edge wb_data=0x1234, wb_rd=5, stall never 1.
- LB addr=0x103, ready=1, rsp next cycle rdata=0x80FF_0000 -> stall 1 for one cycle, wb_data=0xFFFF_FF80.
- SH addr=0x102, rv1=0xBEEF, ready low 3 cycles -> req_valid 4 cycles, we=1100, wdata=0xBEEF_0000, stall 3 cycles, wb_reg_wr=0.
- LW addr=0x101 -> no request, misalign_err pulse, wb_reg_wr=0, stall 0.
- TIMEOUT_CYC=4, load accepted, no response -> bus_err after 4 WAIT cycles; late rsp_valid ignored.
- reset_n low in WAIT -> req_valid/stall 0, wb_* 0, subsequent rsp ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared encodings for the memory-stage load/store unit:
//   - writeback source select codes
//   - func3 width/sign codes
//   - lane-0 store byte-enable patterns
//   - FSM state type
//   - misalignment rule helper
// ----------------------------------------------------------------------------
package lsu_pkg;

  // Writeback source select
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_LOAD  = 2'b01;
  localparam logic [1:0] WB_IMM   = 2'b10;
  localparam logic [1:0] WB_PCIMM = 2'b11;

  // Load width / sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Store byte enables as presented by the pipeline (lane 0 based)
  localparam logic [3:0] DWE_B = 4'b0001;
  localparam logic [3:0] DWE_H = 4'b0011;
  localparam logic [3:0] DWE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_e;

  // Loads are judged by func3, stores by their byte-enable pattern.
  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [2:0] func3,
                                         input logic [3:0] dwe,
                                         input logic [1:0] a);
    logic mis;
    if (is_load) begin
      mis = (((func3 == F3_H) || (func3 == F3_HU)) && a[0]) ||
            ((func3 == F3_W) && (a != 2'b00));
    end else begin
      mis = ((dwe == DWE_H) && a[0]) ||
            ((dwe == DWE_W) && (a != 2'b00));
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational load-data extraction: picks the addressed byte/half out of
// the returned word and sign- or zero-extends it according to func3.
// Ports:
//   rdata  in  XLEN  raw word from data memory
//   a      in  2     byte offset within the word
//   func3  in  3     width/sign code (B, H, W, BU, HU)
//   data   out XLEN  extended load value
// ----------------------------------------------------------------------------
module load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      a,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Half-words only ever sit in lane 0 or lane 2 once misalignment is excluded.
  assign byte_sel = rdata[{a, 3'b000} +: 8];
  assign half_sel = rdata[{a[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (func3)
      F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
// Memory stage of the pipeline: executes loads/stores from the registered
// mem_* stage signals over a valid/ready request + response-valid bus,
// produces the registered writeback payload, and stalls upstream while an
// access is outstanding. Handles lane steering, load extension,
// misalignment drop and bus timeout.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   mem_*_in                execute/memory pipeline register contents
//   dmem_req_valid/ready    request handshake
//   dmem_addr/we/wdata      word address, byte strobes, steered store data
//   dmem_rsp_valid/rdata    read response
//   stall                   freeze upstream pipeline registers
//   wb_rd/wb_reg_wr/wb_data registered writeback payload
//   misalign_err, bus_err   one-cycle error pulses
// ----------------------------------------------------------------------------
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] mem_alu_out_in,
  input  logic [XLEN-1:0] mem_rv1_in,
  input  logic [XLEN-1:0] mem_pc_imm_in,
  input  logic [XLEN-1:0] mem_imm_in,
  input  logic [4:0]      mem_rd_in,
  input  logic [1:0]      mem_reg_in_sel_in,
  input  logic [3:0]      mem_dwe_in,
  input  logic [2:0]      mem_func3_in,
  input  logic            mem_mem_reg_in,
  input  logic            mem_reg_wr_in,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_we,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_wr,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err,
  output logic            bus_err
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_state_e      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [1:0]      a;
  logic            is_load, mem_op, mis_drop, tmo_reached;
  logic            req, complete, timeout_hit, stall_int;
  logic [XLEN-1:0] load_data, wb_data_next;

  assign a       = mem_alu_out_in[1:0];
  assign is_load = mem_mem_reg_in;
  assign mem_op  = mem_mem_reg_in | (mem_dwe_in != 4'b0000);

  // Misalignment is only evaluated when a new op is presented; anything
  // that reached REQ/WAIT was already known to be aligned.
  assign mis_drop = (state_reg == IDLE) && mem_op &&
                    is_misaligned(is_load, mem_func3_in, mem_dwe_in, a);

  assign tmo_reached = (TIMEOUT_CYC != 0) && (32'(cnt_reg) == TIMEOUT_CYC - 1);

  assign dmem_addr  = {mem_alu_out_in[XLEN-1:2], 2'b00};
  assign dmem_we    = is_load ? 4'b0000 : (mem_dwe_in << a);
  assign dmem_wdata = mem_rv1_in << {a, 3'b000};

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata (dmem_rdata),
    .a     (a),
    .func3 (mem_func3_in),
    .data  (load_data)
  );

  always_comb begin
    state_next  = state_reg;
    req         = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_op && !mis_drop) begin
          req = 1'b1;
          if (dmem_req_ready) begin
            if (is_load) state_next = WAIT;
            else         complete   = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        // An accept in the last permitted cycle still wins over the timeout.
        if (dmem_req_ready) begin
          if (is_load) begin
            state_next = WAIT;
          end else begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end else if (tmo_reached) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (tmo_reached) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change and only advances while
  // lingering in REQ or WAIT.
  always_comb begin
    cnt_next = '0;
    if ((state_next == state_reg) && (state_reg != IDLE)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign stall_int      = mem_op & ~complete & ~mis_drop & ~timeout_hit;
  assign stall          = reset_n & stall_int;
  assign dmem_req_valid = reset_n & req;

  always_comb begin
    wb_data_next = mem_alu_out_in;
    case (mem_reg_in_sel_in)
      WB_ALU:   wb_data_next = mem_alu_out_in;
      WB_LOAD:  wb_data_next = load_data;
      WB_IMM:   wb_data_next = mem_imm_in;
      WB_PCIMM: wb_data_next = mem_pc_imm_in;
      default:  wb_data_next = mem_alu_out_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wb_rd        <= '0;
      wb_reg_wr    <= 1'b0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wb_rd        <= mem_rd_in;
      // A stalled cycle retires nothing, so it writes back a bubble.
      wb_reg_wr    <= mem_reg_wr_in & ~stall_int & ~mis_drop & ~timeout_hit;
      wb_data      <= wb_data_next;
      misalign_err <= mis_drop;
      bus_err      <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Scoreboard bench: the stimulus process plays both the pipeline and the
// memory, pushes the expected retirement of each instruction into a queue,
// and a negedge monitor pops/compares whenever an instruction retires.
// ----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  localparam int unsigned T = 4;

  logic        clk;
  logic        reset_n;
  logic [31:0] mem_alu_out_in, mem_rv1_in, mem_pc_imm_in, mem_imm_in;
  logic [4:0]  mem_rd_in;
  logic [1:0]  mem_reg_in_sel_in;
  logic [3:0]  mem_dwe_in;
  logic [2:0]  mem_func3_in;
  logic        mem_mem_reg_in, mem_reg_wr_in;
  logic        dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [4:0]  wb_rd;
  logic        wb_reg_wr;
  logic [31:0] wb_data;
  logic        misalign_err, bus_err;

  mem_stage_lsu #(.TIMEOUT_CYC(T), .XLEN(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .mem_alu_out_in    (mem_alu_out_in),
    .mem_rv1_in        (mem_rv1_in),
    .mem_pc_imm_in     (mem_pc_imm_in),
    .mem_imm_in        (mem_imm_in),
    .mem_rd_in         (mem_rd_in),
    .mem_reg_in_sel_in (mem_reg_in_sel_in),
    .mem_dwe_in        (mem_dwe_in),
    .mem_func3_in      (mem_func3_in),
    .mem_mem_reg_in    (mem_mem_reg_in),
    .mem_reg_wr_in     (mem_reg_wr_in),
    .dmem_req_valid    (dmem_req_valid),
    .dmem_req_ready    (dmem_req_ready),
    .dmem_addr         (dmem_addr),
    .dmem_we           (dmem_we),
    .dmem_wdata        (dmem_wdata),
    .dmem_rsp_valid    (dmem_rsp_valid),
    .dmem_rdata        (dmem_rdata),
    .stall             (stall),
    .wb_rd             (wb_rd),
    .wb_reg_wr         (wb_reg_wr),
    .wb_data           (wb_data),
    .misalign_err      (misalign_err),
    .bus_err           (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        mis;
    logic        berr;
    int          len;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   txn = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endfunction

  // Reference: extract and extend load data with plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [31:0] rd_word, input int a, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (rd_word >> (8 * a)) & 32'hFF;
    h = (rd_word >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd_word;
    endcase
  endfunction

  // Monitor: at each negedge, retire the previous cycle's instruction if it
  // was not stalled, then account for the current cycle's request.
  bit prev_valid = 0;
  bit prev_stall = 0;
  int cyc = 0;
  int reqs = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_valid = 0;
    end else begin
      if (prev_valid) begin
        if (!prev_stall) begin
          exp_t e;
          e = q.pop_front();
          txn++;
          $display("txn %0d rd=%0d wr=%0b data=%h mis=%0b berr=%0b cycles=%0d",
                   txn, wb_rd, wb_reg_wr, wb_data, misalign_err, bus_err, cyc);
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_reg_wr", 32'(wb_reg_wr), 32'(e.rw));
          if (e.rw) chk("wb_data", wb_data, e.data);
          chk("misalign_err", 32'(misalign_err), 32'(e.mis));
          chk("bus_err", 32'(bus_err), 32'(e.berr));
          chk("latency", cyc, e.len);
          chk("req_cycles", reqs, e.reqs);
          cyc = 0;
          reqs = 0;
        end else begin
          chk("bubble_wr", 32'(wb_reg_wr), 32'd0);
          chk("bubble_err", 32'({misalign_err, bus_err}), 32'd0);
        end
      end
      if (q.size() == 0) begin
        prev_valid = 0;
      end else begin
        cyc++;
        if (dmem_req_valid) begin
          reqs++;
          chk("dmem_addr", dmem_addr, q[0].addr);
          chk("dmem_we", 32'(dmem_we), 32'(q[0].we));
          chk("dmem_wdata", dmem_wdata, q[0].wdata);
        end
        prev_stall = stall;
        prev_valid = 1;
      end
    end
  end

  // Presents one instruction, predicts its retirement, and plays memory for
  // it: ready after dr refused cycles, response dr+1+ds cycles after start.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rv1,
                       input logic [31:0] pci, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [1:0] sel,
                       input logic [3:0] dwe, input logic [2:0] f3,
                       input logic ld, input logic rw,
                       input int dr, input int ds, input logic [31:0] rword);
    exp_t e;
    int   a;
    bit   memop, mis;
    a     = int'(alu[1:0]);
    memop = ld || (dwe != 4'b0000);
    if (ld) mis = ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 == 1)) || (f3 == 3'b010 && a != 0);
    else    mis = (dwe == 4'b0011 && (a % 2 == 1)) || (dwe == 4'b1111 && a != 0);
    mis = mis && memop;
    e.rd    = rd;
    e.addr  = alu & 32'hFFFF_FFFC;
    e.we    = ld ? 4'b0000 : 4'((32'(dwe) << a) & 32'hF);
    e.wdata = rv1 << (8 * a);
    e.mis   = 0;
    e.berr  = 0;
    e.rw    = rw;
    case (sel)
      2'b00:   e.data = alu;
      2'b10:   e.data = imm;
      2'b11:   e.data = pci;
      default: e.data = ref_load(rword, a, f3);
    endcase
    if (!memop) begin
      e.len = 1; e.reqs = 0;
    end else if (mis) begin
      e.len = 1; e.reqs = 0; e.rw = 0; e.mis = 1;
    end else if (dr > int'(T)) begin
      e.len = int'(T) + 1; e.reqs = int'(T) + 1; e.rw = 0; e.berr = 1;
    end else if (!ld) begin
      e.len = dr + 1; e.reqs = dr + 1;
    end else if (ds >= int'(T)) begin
      e.len = dr + int'(T) + 1; e.reqs = dr + 1; e.rw = 0; e.berr = 1;
    end else begin
      e.len = dr + ds + 2; e.reqs = dr + 1;
    end
    q.push_back(e);

    mem_alu_out_in = alu; mem_rv1_in = rv1; mem_pc_imm_in = pci; mem_imm_in = imm;
    mem_rd_in = rd; mem_reg_in_sel_in = sel; mem_dwe_in = dwe; mem_func3_in = f3;
    mem_mem_reg_in = ld; mem_reg_wr_in = rw;
    for (int c = 0; c < e.len; c++) begin
      if (memop && !mis) dmem_req_ready = (c == dr) ? 1'b1 : ((c < dr) ? 1'b0 : 1'($urandom_range(0, 1)));
      else               dmem_req_ready = 1'($urandom_range(0, 1));
      if (ld && !mis && c == dr + 1 + ds) begin
        dmem_rsp_valid = 1'b1; dmem_rdata = rword;
      end else if (ld && !mis && c > dr) begin
        dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
      end else begin
        dmem_rsp_valid = ($urandom_range(0, 3) == 0); dmem_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic set_nop();
    mem_mem_reg_in = 0; mem_dwe_in = 4'b0000; mem_reg_wr_in = 0;
    mem_reg_in_sel_in = 2'b00; dmem_req_ready = 0; dmem_rsp_valid = 0;
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [3:0] st_dwe [3];
    ld_f3  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_dwe = '{4'b0001, 4'b0011, 4'b1111};

    // Reset with an aligned load presented: outputs must stay quiet.
    reset_n = 0;
    mem_alu_out_in = 32'h100; mem_rv1_in = 0; mem_pc_imm_in = 0; mem_imm_in = 0;
    mem_rd_in = 5'd1; mem_reg_in_sel_in = 2'b01; mem_dwe_in = 0; mem_func3_in = 3'b010;
    mem_mem_reg_in = 1; mem_reg_wr_in = 1; dmem_req_ready = 1; dmem_rsp_valid = 1;
    dmem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    set_nop();
    @(posedge clk); #1;
    mon_en = 1;

    // Directed cases
    issue(32'h1234, 0, 0, 0, 5'd5, 2'b00, 4'b0000, 3'b000, 0, 1, 0, 0, 0);
    issue(32'h103, 0, 0, 0, 5'd7, 2'b01, 4'b0000, 3'b000, 1, 1, 0, 0, 32'h80FF_0000);
    issue(32'h102, 32'hBEEF, 0, 0, 5'd0, 2'b00, 4'b0011, 3'b001, 0, 0, 3, 0, 0);
    issue(32'h101, 0, 0, 0, 5'd8, 2'b01, 4'b0000, 3'b010, 1, 1, 0, 0, 0);
    issue(32'h200, 0, 0, 0, 5'd9, 2'b01, 4'b0000, 3'b010, 1, 1, 0, 6, 32'h1111_2222);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        int r;
        r = $urandom_range(0, 2);
        issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), (r == 0) ? 2'b00 : 2'(r + 1),
              4'b0000, 3'($urandom), 0, 1'($urandom), 0, 0, 0);
      end else if (kind == 1) begin
        issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'b01, 4'b0000,
              ld_f3[$urandom_range(0, 4)], 1, ($urandom_range(0, 7) != 0),
              $urandom_range(0, 5), $urandom_range(0, 4), $urandom);
      end else begin
        int s;
        s = $urandom_range(0, 2);
        issue($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'b00, st_dwe[s],
              3'(s), 0, 0, $urandom_range(0, 5), 0, 0);
      end
    end

    set_nop();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    mon_en = 0;

    // Reset while a load waits for its response.
    mem_alu_out_in = 32'h300; mem_rd_in = 5'd9; mem_reg_in_sel_in = 2'b01;
    mem_func3_in = 3'b010; mem_mem_reg_in = 1; mem_reg_wr_in = 1; mem_dwe_in = 0;
    dmem_req_ready = 1; dmem_rsp_valid = 0;
    @(negedge clk);
    chk("mr_req_issue", 32'(dmem_req_valid), 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 0;
    @(negedge clk);
    chk("mr_wait_stall", 32'(stall), 32'd1);
    chk("mr_wait_noreq", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 0;
    @(negedge clk);
    chk("mr_rst_req", 32'(dmem_req_valid), 32'd0);
    chk("mr_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    mem_mem_reg_in = 0; mem_reg_in_sel_in = 2'b00; mem_alu_out_in = 32'h55; mem_rd_in = 5'd3;
    dmem_rsp_valid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("mr_post_wr", 32'(wb_reg_wr), 32'd0);
    chk("mr_post_data", wb_data, 32'd0);
    chk("mr_post_rd", 32'(wb_rd), 32'd0);
    chk("mr_post_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    // New load presented with a stray response: must request, not complete.
    mem_mem_reg_in = 1; mem_reg_in_sel_in = 2'b01; mem_alu_out_in = 32'h304; mem_rd_in = 5'd4;
    dmem_req_ready = 0; dmem_rsp_valid = 1;
    @(negedge clk);
    chk("mr_alu_data", wb_data, 32'h55);
    chk("mr_alu_wr", 32'(wb_reg_wr), 32'd1);
    chk("mr_alu_rd", 32'(wb_rd), 32'd3);
    chk("mr_stray_stall", 32'(stall), 32'd1);
    chk("mr_stray_req", 32'(dmem_req_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
